serv_rf_sram_resp: RTL and testbench

- RAM-side responder for the SERV register-file RAM interface.
- Accepts the word-wide write and read requests the interface issues, with one-cycle synchronous read latency.
- Drives a single-port gf180mcu SRAM macro through its active-low control pins.
- After reset, zero-fills every register-file word before raising o_init_done; SoC glue holds the CPU in reset until then.

---
 rtl/serv_rf_pkg.sv | 19 +
 rtl/serv_rf_sram_resp.sv | 113 +++++++++++
 tb/tb_serv_rf_sram_resp.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/serv_rf_pkg.sv
// Shared types and geometry helpers for the SERV register-file RAM path.
package serv_rf_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Number of RAM words holding 32 GPRs plus the CSR registers.
  function automatic int calc_depth(input int width, input int csr_regs);
    return 32 * (32 + csr_regs) / width;
  endfunction

  // Word address width for a given depth.
  function automatic int calc_aw(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/serv_rf_sram_resp.sv
// RAM-side responder: zero-fills the register file after reset, then
// serves word writes and 1-cycle-latency reads from a single-port macro.
module serv_rf_sram_resp
  import serv_rf_pkg::*;
#(
  parameter int width    = 8,
  parameter int csr_regs = 4,
  parameter int depth    = calc_depth(width, csr_regs),
  parameter int aw       = calc_aw(depth),
  parameter int sram_aw  = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [aw-1:0]      i_waddr,
  input  logic [width-1:0]   i_wdata,
  input  logic               i_wen,
  input  logic [aw-1:0]      i_raddr,
  output logic [width-1:0]   o_rdata,
  output logic               o_init_done,
  output logic               o_wr_dropped,
  output logic               o_sram_cen,
  output logic               o_sram_gwen,
  output logic [width-1:0]   o_sram_wen,
  output logic [sram_aw-1:0] o_sram_a,
  output logic [width-1:0]   o_sram_d,
  input  logic [width-1:0]   i_sram_q
);

  // One extra bit so depth == 2**aw still compares correctly.
  localparam logic [aw:0]   DEPTH_W = (aw + 1)'(depth);
  localparam logic [aw-1:0] LAST    = aw'(depth - 1);

  state_e           state;
  logic [aw-1:0]    cnt;
  logic             rd_pend;
  logic             oor_q;
  logic [width-1:0] hold;
  logic             waddr_ok;
  logic             raddr_ok;

  assign waddr_ok = {1'b0, i_waddr} < DEPTH_W;
  assign raddr_ok = {1'b0, i_raddr} < DEPTH_W;

  // Read data comes straight from the macro on the cycle after a read,
  // otherwise the last presented value is replayed so writes don't disturb it.
  assign o_rdata = rd_pend ? (oor_q ? '0 : i_sram_q) : hold;

  // Macro control: fill during INIT, then write wins over read in RUN.
  // Reset forces the macro idle so nothing is corrupted while held.
  always_comb begin
    o_sram_cen  = 1'b1;
    o_sram_gwen = 1'b1;
    o_sram_wen  = '1;
    o_sram_a    = '0;
    o_sram_d    = '0;
    if (!i_rst_n) begin
      o_sram_cen = 1'b1;
    end else if (state == INIT) begin
      o_sram_cen  = 1'b0;
      o_sram_gwen = 1'b0;
      o_sram_wen  = '0;
      o_sram_a    = sram_aw'(cnt);
    end else if (i_wen) begin
      if (waddr_ok) begin
        o_sram_cen  = 1'b0;
        o_sram_gwen = 1'b0;
        o_sram_wen  = '0;
        o_sram_a    = sram_aw'(i_waddr);
        o_sram_d    = i_wdata;
      end
    end else begin
      o_sram_cen = !raddr_ok;
      o_sram_a   = sram_aw'(i_raddr);
    end
  end

  // Fill sequencer, read-pending tracking and sticky drop flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= INIT;
      cnt          <= '0;
      rd_pend      <= 1'b0;
      oor_q        <= 1'b0;
      hold         <= '0;
      o_init_done  <= 1'b0;
      o_wr_dropped <= 1'b0;
    end else begin
      hold <= o_rdata;
      case (state)
        INIT: begin
          cnt     <= cnt + 1'b1;
          rd_pend <= 1'b0;
          if (i_wen) o_wr_dropped <= 1'b1;
          if (cnt == LAST) begin
            state       <= RUN;
            o_init_done <= 1'b1;
          end
        end
        RUN: begin
          if (i_wen) begin
            rd_pend <= 1'b0;
            if (!waddr_ok) o_wr_dropped <= 1'b1;
          end else begin
            rd_pend <= 1'b1;
            oor_q   <= !raddr_ok;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_serv_rf_sram_resp.sv
// Bench for serv_rf_sram_resp: behavioural macro, register-file model,
// per-cycle compare plus directed literal expectations.
module tb_serv_rf_sram_resp;
  localparam int W     = 8;
  localparam int DEPTH = 144;
  localparam int AW    = 8;
  localparam int SAW   = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic [AW-1:0]  waddr = '0;
  logic [W-1:0]   wdata = '0;
  logic           wen = 1'b0;
  logic [AW-1:0]  raddr = '0;
  logic [W-1:0]   rdata;
  logic           init_done, wr_dropped;
  logic           cen, gwen;
  logic [W-1:0]   swen, sd, sq;
  logic [SAW-1:0] sa;

  int checks = 0;
  int failures = 0;

  serv_rf_sram_resp dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_waddr(waddr), .i_wdata(wdata),
    .i_wen(wen), .i_raddr(raddr), .o_rdata(rdata), .o_init_done(init_done),
    .o_wr_dropped(wr_dropped), .o_sram_cen(cen), .o_sram_gwen(gwen),
    .o_sram_wen(swen), .o_sram_a(sa), .o_sram_d(sd), .i_sram_q(sq)
  );

  always #5 clk = ~clk;

  // Behavioural single-port macro; unwritten words hold a marker pattern.
  logic [W-1:0] mem [256];
  initial for (int i = 0; i < 256; i++) mem[i] = 8'h77;
  always @(posedge clk) begin
    if (!cen) begin
      if (!gwen) mem[sa] <= (mem[sa] & swen) | (sd & ~swen);
      else       sq <= mem[sa];
    end
  end

  // Reference model: register-file contents and what the reader should see.
  logic [W-1:0] m_rf [DEPTH];
  int           m_cnt = 0;
  logic         m_done = 1'b0;
  logic         m_drop = 1'b0;
  logic [W-1:0] m_rdata = '0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt = 0; m_done = 1'b0; m_drop = 1'b0; m_rdata = '0;
    end else if (!m_done) begin
      if (wen) m_drop = 1'b1;
      m_cnt++;
      if (m_cnt == DEPTH) begin
        m_done = 1'b1;
        for (int i = 0; i < DEPTH; i++) m_rf[i] = '0;
      end
    end else if (wen) begin
      if (waddr < DEPTH) m_rf[waddr] = wdata;
      else               m_drop = 1'b1;
    end else begin
      m_rdata = (raddr < DEPTH) ? m_rf[raddr] : '0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    chk("rdata", 32'(rdata), 32'(m_rdata));
    chk("init_done", 32'(init_done), 32'(m_done));
    chk("wr_dropped", 32'(wr_dropped), 32'(m_drop));
    if (!rst_n) chk("cen_in_reset", 32'(cen), 32'd1);
    else if (!m_done) begin
      chk("fill_ctl", {30'd0, cen, gwen}, 32'd0);
      chk("fill_addr", 32'(sa), 32'(m_cnt));
      chk("fill_data", 32'(sd), 32'd0);
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d);
    wen = 1'b1; waddr = a; wdata = d;
    cyc();
    wen = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a);
    raddr = a;
    cyc();
  endtask

  task automatic wait_fill(input string nm, input int expect_cycles);
    int n;
    n = 0;
    while (!init_done && n < 200) begin
      cyc();
      n++;
    end
    chk(nm, 32'(n), 32'(expect_cycles));
  endtask

  initial begin
    #1 rst_n = 1'b0;
    @(negedge clk); #1;
    chk("rst_cen", 32'(cen), 32'd1);
    chk("rst_done", 32'(init_done), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Zero-fill: exactly DEPTH edges, words beyond DEPTH untouched.
    wait_fill("fill_cycles", 144);
    chk("fill_drop", 32'(wr_dropped), 32'd0);
    begin
      int nz;
      nz = 0;
      for (int i = 0; i < DEPTH; i++) if (mem[i] !== 8'h00) nz++;
      chk("fill_mem_zero", 32'(nz), 32'd0);
    end
    chk("mem144_untouched", 32'(mem[144]), 32'h77);

    // Write then read back, plus a neighbour that must still be zero.
    wr(37, 8'hA5);
    rd(37);
    @(negedge clk); chk("rd37", 32'(rdata), 32'hA5);
    rd(38);
    @(negedge clk); chk("rd38", 32'(rdata), 32'h00);

    // Read data held across a burst of writes.
    rd(37);
    wr(5, 8'h11); chk("hold1", 32'(rdata), 32'hA5);
    wr(5, 8'h22); chk("hold2", 32'(rdata), 32'hA5);
    wr(5, 8'h33); chk("hold3", 32'(rdata), 32'hA5);
    rd(5);
    @(negedge clk); chk("rd5", 32'(rdata), 32'h33);

    // Read-after-write on the next cycle, then a streaming read sweep.
    wr(10, 8'h3C);
    rd(10);
    @(negedge clk); chk("raw10", 32'(rdata), 32'h3C);
    for (int i = 0; i < 18; i++) rd(AW'(i));

    // Out-of-range write and read.
    wen = 1'b1; waddr = 200; wdata = 8'h5A;
    #1 chk("oor_wr_cen", 32'(cen), 32'd1);
    cyc(); wen = 1'b0;
    @(negedge clk);
    chk("oor_drop", 32'(wr_dropped), 32'd1);
    chk("mem200", 32'(mem[200]), 32'h77);
    rd(200);
    @(negedge clk); chk("rd200", 32'(rdata), 32'h00);

    // Asynchronous mid-RUN reset clears state and restarts the fill.
    wr(3, 8'hFF);
    rd(3);
    @(negedge clk); chk("rd3_pre", 32'(rdata), 32'hFF);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_done", 32'(init_done), 32'd0);
    chk("arst_rdata", 32'(rdata), 32'd0);
    chk("arst_drop", 32'(wr_dropped), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    cyc(); cyc();
    wr(3, 8'hEE);
    chk("init_drop", 32'(wr_dropped), 32'd1);
    wait_fill("refill_cycles", 141);
    rd(3);
    @(negedge clk); chk("rd3_post", 32'(rdata), 32'h00);
    chk("drop_sticky", 32'(wr_dropped), 32'd1);

    cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

endmodule
